// File: rtl/uart_cmd_master_if.sv
// Single-master bus between the UART command decoder and its target.
// Signal names keep the master-side _o/_i view used on the bus.
interface uart_cmd_master_if;
  logic [7:0] adr_o;
  logic [7:0] dat_o;
  logic       stb_o;
  logic       we_o;
  logic       ack_i;
  logic [7:0] dat_i;

  modport master (output adr_o, dat_o, stb_o, we_o, input ack_i, dat_i);
  modport slave  (input adr_o, dat_o, stb_o, we_o, output ack_i, dat_i);
endinterface

// File: rtl/uart_cmd_master.sv
// Decodes framed UART command bytes (cmd, adr[, dat]) into one bus read/write
// per frame, with bus and inter-byte timeouts and a one-cycle result strobe.
module uart_cmd_master #(
  parameter int BUS_TIMEOUT  = 255,
  parameter int BYTE_TIMEOUT = 100000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  uart_cmd_master_if.master bus,
  output logic       res_valid,
  output logic       res_ack,
  output logic [7:0] res_adr,
  output logic [7:0] res_dat,
  output logic       busy,
  output logic       frame_err,
  output logic       rx_drop
);
  localparam logic [15:0] BUS_LAST  = 16'(BUS_TIMEOUT - 1);
  localparam logic [23:0] BYTE_LAST = 24'(BYTE_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ADR, DAT, BUS} state_t;

  state_t      state, state_nxt;
  logic        cmd_we, cmd_we_nxt;
  logic [15:0] bus_cnt, bus_cnt_nxt;
  logic [23:0] byte_cnt, byte_cnt_nxt;
  logic [7:0]  adr_nxt, dat_nxt, radr_nxt, rdat_nxt;
  logic        stb_nxt, we_nxt, rv_nxt, ra_nxt, ferr_nxt, drop_nxt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cmd_we    <= 1'b0;
      bus_cnt   <= '0;
      byte_cnt  <= '0;
      bus.adr_o <= '0;
      bus.dat_o <= '0;
      bus.stb_o <= 1'b0;
      bus.we_o  <= 1'b0;
      res_valid <= 1'b0;
      res_ack   <= 1'b0;
      res_adr   <= '0;
      res_dat   <= '0;
      frame_err <= 1'b0;
      rx_drop   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cmd_we    <= cmd_we_nxt;
      bus_cnt   <= bus_cnt_nxt;
      byte_cnt  <= byte_cnt_nxt;
      bus.adr_o <= adr_nxt;
      bus.dat_o <= dat_nxt;
      bus.stb_o <= stb_nxt;
      bus.we_o  <= we_nxt;
      res_valid <= rv_nxt;
      res_ack   <= ra_nxt;
      res_adr   <= radr_nxt;
      res_dat   <= rdat_nxt;
      frame_err <= ferr_nxt;
      rx_drop   <= drop_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cmd_we_nxt   = cmd_we;
    bus_cnt_nxt  = bus_cnt;
    byte_cnt_nxt = byte_cnt;
    adr_nxt      = bus.adr_o;
    dat_nxt      = bus.dat_o;
    stb_nxt      = bus.stb_o;
    we_nxt       = bus.we_o;
    rv_nxt       = 1'b0;
    ra_nxt       = res_ack;
    radr_nxt     = res_adr;
    rdat_nxt     = res_dat;
    ferr_nxt     = 1'b0;
    drop_nxt     = 1'b0;
    unique case (state)
      IDLE: if (rx_valid) begin
        if (rx_data == 8'h00 || rx_data == 8'h01) begin
          state_nxt    = ADR;
          cmd_we_nxt   = rx_data[0];
          byte_cnt_nxt = '0;
        end else begin
          ferr_nxt = 1'b1;
        end
      end
      ADR, DAT: begin
        if (rx_valid) begin
          byte_cnt_nxt = '0;
          if (state == ADR) adr_nxt = rx_data;
          else              dat_nxt = rx_data;
          if (state == ADR && cmd_we) begin
            state_nxt = DAT;
          end else begin
            state_nxt   = BUS;
            stb_nxt     = 1'b1;
            we_nxt      = cmd_we;
            bus_cnt_nxt = '0;
          end
        end else if (byte_cnt == BYTE_LAST) begin
          state_nxt = IDLE;
          ferr_nxt  = 1'b1;
        end else begin
          byte_cnt_nxt = byte_cnt + 24'd1;
        end
      end
      BUS: begin
        drop_nxt = rx_valid;
        // A byte landing in the completion cycle is dropped too; IDLE
        // only starts listening the cycle after.
        if (bus.ack_i || bus_cnt == BUS_LAST) begin
          state_nxt = IDLE;
          stb_nxt   = 1'b0;
          we_nxt    = 1'b0;
          rv_nxt    = 1'b1;
          ra_nxt    = bus.ack_i;
          radr_nxt  = bus.adr_o;
          rdat_nxt  = !bus.ack_i ? 8'h00 : (cmd_we ? bus.dat_o : bus.dat_i);
        end else begin
          bus_cnt_nxt = bus_cnt + 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
endmodule

// File: tb/tb_uart_cmd_master.sv
// Directed bench: per-cycle vector table plus hand sequences for byte
// timeout, expiry-cycle byte, and mid-transaction reset.
module tb_uart_cmd_master;
  localparam int BT = 20;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       res_valid, res_ack, busy, frame_err, rx_drop;
  logic [7:0] res_adr, res_dat;
  int total = 0;
  int bad = 0;

  uart_cmd_master_if bif ();

  uart_cmd_master #(.BUS_TIMEOUT(4), .BYTE_TIMEOUT(BT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rx_data(rx_data), .rx_valid(rx_valid),
    .bus(bif.master), .res_valid(res_valid), .res_ack(res_ack),
    .res_adr(res_adr), .res_dat(res_dat), .busy(busy),
    .frame_err(frame_err), .rx_drop(rx_drop)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       rxv;
    logic [7:0] rxd;
    logic       ack;
    logic [7:0] di;
    logic [38:0] exp;
  } vec_t;

  function automatic vec_t v(input logic rxv, input logic [7:0] rxd,
      input logic ack, input logic [7:0] di, input logic stb, input logic we,
      input logic [7:0] adr, input logic [7:0] dato, input logic rv,
      input logic ra, input logic [7:0] radr, input logic [7:0] rdat,
      input logic bsy, input logic fe, input logic dr);
    vec_t r;
    r.rxv = rxv; r.rxd = rxd; r.ack = ack; r.di = di;
    r.exp = {stb, we, adr, dato, rv, ra, radr, rdat, bsy, fe, dr};
    return r;
  endfunction

  function automatic logic [38:0] outs();
    return {bif.stb_o, bif.we_o, bif.adr_o, bif.dat_o, res_valid, res_ack,
            res_adr, res_dat, busy, frame_err, rx_drop};
  endfunction

  task automatic chk(input string name, input logic [38:0] act, input logic [38:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic apply(input logic rxv, input logic [7:0] rxd, input logic ack, input logic [7:0] di);
    rx_valid  = rxv;
    rx_data   = rxd;
    bif.ack_i = ack;
    bif.dat_i = di;
    @(posedge clk_i);
    #1;
  endtask

  vec_t tbl[$];
  int   k;

  initial begin
    bif.ack_i = 1'b0;
    bif.dat_i = '0;
    // read 0x42, ack in 3rd strobe cycle
    tbl.push_back(v(1,8'h00,0,8'h00, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 1,0,0));
    tbl.push_back(v(1,8'h42,0,8'h00, 1,0,8'h42,8'h00, 0,0,8'h00,8'h00, 1,0,0));
    tbl.push_back(v(0,8'h00,0,8'h00, 1,0,8'h42,8'h00, 0,0,8'h00,8'h00, 1,0,0));
    tbl.push_back(v(0,8'h00,0,8'h00, 1,0,8'h42,8'h00, 0,0,8'h00,8'h00, 1,0,0));
    tbl.push_back(v(0,8'h00,1,8'hA5, 0,0,8'h42,8'h00, 1,1,8'h42,8'hA5, 0,0,0));
    tbl.push_back(v(0,8'h00,0,8'h00, 0,0,8'h42,8'h00, 0,1,8'h42,8'hA5, 0,0,0));
    // write 0x5A to 0x10, immediate ack
    tbl.push_back(v(1,8'h01,0,8'h00, 0,0,8'h42,8'h00, 0,1,8'h42,8'hA5, 1,0,0));
    tbl.push_back(v(1,8'h10,0,8'h00, 0,0,8'h10,8'h00, 0,1,8'h42,8'hA5, 1,0,0));
    tbl.push_back(v(1,8'h5A,0,8'h00, 1,1,8'h10,8'h5A, 0,1,8'h42,8'hA5, 1,0,0));
    tbl.push_back(v(0,8'h00,1,8'hEE, 0,0,8'h10,8'h5A, 1,1,8'h10,8'h5A, 0,0,0));
    tbl.push_back(v(0,8'h00,0,8'h00, 0,0,8'h10,8'h5A, 0,1,8'h10,8'h5A, 0,0,0));
    // read 0x20, no ack: 4 strobe cycles, drops mid-BUS and in exit cycle
    tbl.push_back(v(1,8'h00,0,8'h00, 0,0,8'h10,8'h5A, 0,1,8'h10,8'h5A, 1,0,0));
    tbl.push_back(v(1,8'h20,0,8'h00, 1,0,8'h20,8'h5A, 0,1,8'h10,8'h5A, 1,0,0));
    tbl.push_back(v(0,8'h00,0,8'h00, 1,0,8'h20,8'h5A, 0,1,8'h10,8'h5A, 1,0,0));
    tbl.push_back(v(1,8'h99,0,8'h00, 1,0,8'h20,8'h5A, 0,1,8'h10,8'h5A, 1,0,1));
    tbl.push_back(v(0,8'h00,0,8'h00, 1,0,8'h20,8'h5A, 0,1,8'h10,8'h5A, 1,0,0));
    tbl.push_back(v(1,8'h00,0,8'h00, 0,0,8'h20,8'h5A, 1,0,8'h20,8'h00, 0,0,1));
    // bad command, then ack while idle is ignored
    tbl.push_back(v(1,8'h07,0,8'h00, 0,0,8'h20,8'h5A, 0,0,8'h20,8'h00, 0,1,0));
    tbl.push_back(v(0,8'h00,1,8'hFF, 0,0,8'h20,8'h5A, 0,0,8'h20,8'h00, 0,0,0));

    #12;
    chk("reset", outs(), 39'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    foreach (tbl[i])
      begin
        apply(tbl[i].rxv, tbl[i].rxd, tbl[i].ack, tbl[i].di);
        chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
      end

    // inter-byte timeout: frame_err exactly BT idle cycles after the command
    apply(1, 8'h00, 0, 8'h00);
    k = 0;
    for (int c = 1; c <= BT + 5; c++) begin
      apply(0, 8'h00, 0, 8'h00);
      if (frame_err) begin k = c; break; end
    end
    chk("byte_timeout_cycles", 39'(k), 39'(BT));
    chk("byte_timeout_idle", {38'h0, busy}, 39'h0);
    apply(1, 8'h00, 0, 8'h00);
    apply(1, 8'h33, 0, 8'h00);
    chk("rd33_stb", {bif.stb_o, bif.we_o, bif.adr_o}, {29'h0, 1'b1, 1'b0, 8'h33});
    apply(0, 8'h00, 1, 8'h77);
    chk("rd33_res", {res_valid, res_ack, res_adr, res_dat}, {21'h0, 1'b1, 1'b1, 8'h33, 8'h77});

    // byte arriving in the expiry cycle wins over the timeout
    apply(1, 8'h00, 0, 8'h00);
    k = 0;
    for (int c = 1; c < BT; c++) begin
      apply(0, 8'h00, 0, 8'h00);
      if (frame_err) k++;
    end
    apply(1, 8'h44, 0, 8'h00);
    chk("expiry_byte_wins", {frame_err, bif.stb_o, bif.adr_o, 8'(k)},
        {21'h0, 1'b0, 1'b1, 8'h44, 8'h00});
    apply(0, 8'h00, 1, 8'h01);
    chk("rd44_res", {res_valid, res_ack, res_adr, res_dat}, {21'h0, 1'b1, 1'b1, 8'h44, 8'h01});

    // reset mid-strobe: strobe drops asynchronously, no result emitted
    apply(1, 8'h00, 0, 8'h00);
    apply(1, 8'h55, 0, 8'h00);
    chk("rst_pre_stb", {38'h0, bif.stb_o}, 39'h1);
    #3 rst_i = 1'b1;
    #1;
    chk("rst_async", outs(), 39'h0);
    k = 0;
    apply(0, 8'h00, 1, 8'h99);
    if (res_valid) k++;
    rst_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      apply(0, 8'h00, 0, 8'h00);
      if (res_valid) k++;
    end
    chk("rst_no_result", 39'(k), 39'h0);
    apply(1, 8'h00, 0, 8'h00);
    apply(1, 8'h66, 0, 8'h00);
    apply(0, 8'h00, 1, 8'hAB);
    chk("post_rst_read", outs(),
        {1'b0, 1'b0, 8'h66, 8'h00, 1'b1, 1'b1, 8'h66, 8'hAB, 1'b0, 1'b0, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
